learn_costs: RTL and testbench

Neighbor-table learning engine for a wireless-sensor routing node. On each received-packet event (`en` pulse) it searches the neighbor table held in the shared 2048×8 byte-addressed memory (`mem`, 16-bit word port) for the packet's source ID. It updates that neighbor's battery, cost and cluster fields, or appends a new entry. Completion is reported on `done`; `reinit` requests that downstream route selection be rerun.

---
 rtl/learn_costs.sv | 275 +++++++++++++++++++++++++++
 tb/tb_learn_costs.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/learn_costs.sv
// learn_costs: neighbor-table learning engine.
// On each accepted `en` strobe the engine reads the neighbor count, walks
// the table looking for the packet's source ID, then either refreshes the
// matching entry's battery/value/cluster words or appends a new entry and
// bumps the count word (written last so an abort never leaves a dangling
// count). Completion is a one-cycle `done`; `reinit` flags a topology change.
//
// Optional feature macro: LEARN_COSTS_REINIT_EN
//   defined   -> old cluster word is read on a match and `reinit` is driven
//   undefined -> `reinit` is tied low and the match path is one cycle shorter
module learn_costs (
  input  logic        clock,
  input  logic        nrst,
  input  logic        en,
  input  logic [15:0] fsourceID,
  input  logic [15:0] fbatteryStat,
  input  logic [15:0] fValue,
  input  logic [15:0] fclusterID,
  output logic [15:0] address,
  output logic        wr_en,
  input  logic [15:0] mem_data_out,
  output logic [15:0] mem_data_in,
  output logic        reinit,
  output logic        done
);

  localparam logic [15:0] COUNT_ADDR    = 16'h0008;
  localparam logic [15:0] TABLE_BASE    = 16'h0010;
  localparam logic [4:0]  MAX_NEIGHBORS = 5'd16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CNT_ADDR,
    S_CNT_DATA,
    S_SRCH_ADDR,
    S_SRCH_DATA,
    S_RD_CLU,
    S_UPD_BAT,
    S_UPD_VAL,
    S_UPD_CLU,
    S_APP_ID,
    S_APP_BAT,
    S_APP_VAL,
    S_APP_CLU,
    S_APP_CNT,
    S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_id_q, src_id_d;
  logic [15:0] battery_q, battery_d;
  logic [15:0] value_q, value_d;
  logic [15:0] cluster_q, cluster_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] address_q, address_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wdata_q, wdata_d;
  logic        done_q, done_d;
  logic [4:0]  sat_count;
`ifdef LEARN_COSTS_REINIT_EN
  logic        reinit_q, reinit_d;
  logic        clu_diff_q, clu_diff_d;
`endif

  // Byte address of word `off` inside entry `i`.
  function automatic logic [15:0] entry_addr(input logic [4:0] i, input logic [2:0] off);
    return TABLE_BASE + {8'b0, i, 3'b000} + {13'b0, off};
  endfunction

  // The stored count may exceed capacity; never search past the table end.
  assign sat_count = (mem_data_out > 16'd16) ? MAX_NEIGHBORS : mem_data_out[4:0];

  // Next-state and next-output computation for the whole engine.
  always_comb begin
    state_d   = state_q;
    src_id_d  = src_id_q;
    battery_d = battery_q;
    value_d   = value_q;
    cluster_d = cluster_q;
    count_d   = count_q;
    idx_d     = idx_q;
    address_d = address_q;
    wr_en_d   = 1'b0;
    wdata_d   = 16'h0000;
    done_d    = 1'b0;
`ifdef LEARN_COSTS_REINIT_EN
    reinit_d   = 1'b0;
    clu_diff_d = clu_diff_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (en) begin
          src_id_d  = fsourceID;
          battery_d = fbatteryStat;
          value_d   = fValue;
          cluster_d = fclusterID;
          address_d = COUNT_ADDR;
          state_d   = S_CNT_ADDR;
`ifdef LEARN_COSTS_REINIT_EN
          clu_diff_d = 1'b0;
`endif
        end
      end

      S_CNT_ADDR: state_d = S_CNT_DATA;

      S_CNT_DATA: begin
        count_d = sat_count;
        idx_d   = 5'd0;
        if (sat_count == 5'd0) begin
          address_d = entry_addr(5'd0, 3'd0);
          wr_en_d   = 1'b1;
          wdata_d   = src_id_q;
          state_d   = S_APP_ID;
        end else begin
          address_d = entry_addr(5'd0, 3'd0);
          state_d   = S_SRCH_ADDR;
        end
      end

      S_SRCH_ADDR: state_d = S_SRCH_DATA;

      S_SRCH_DATA: begin
        if (mem_data_out == src_id_q) begin
`ifdef LEARN_COSTS_REINIT_EN
          address_d = entry_addr(idx_q, 3'd6);
          state_d   = S_RD_CLU;
`else
          address_d = entry_addr(idx_q, 3'd2);
          wr_en_d   = 1'b1;
          wdata_d   = battery_q;
          state_d   = S_UPD_BAT;
`endif
        end else if ((idx_q + 5'd1) == count_q) begin
          if (count_q < MAX_NEIGHBORS) begin
            idx_d     = count_q;
            address_d = entry_addr(count_q, 3'd0);
            wr_en_d   = 1'b1;
            wdata_d   = src_id_q;
            state_d   = S_APP_ID;
          end else begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        end else begin
          idx_d     = idx_q + 5'd1;
          address_d = entry_addr(idx_q + 5'd1, 3'd0);
          state_d   = S_SRCH_ADDR;
        end
      end

      S_RD_CLU: begin
        address_d = entry_addr(idx_q, 3'd2);
        wr_en_d   = 1'b1;
        wdata_d   = battery_q;
        state_d   = S_UPD_BAT;
      end

      S_UPD_BAT: begin
`ifdef LEARN_COSTS_REINIT_EN
        clu_diff_d = (mem_data_out != cluster_q);
`endif
        address_d = entry_addr(idx_q, 3'd4);
        wr_en_d   = 1'b1;
        wdata_d   = value_q;
        state_d   = S_UPD_VAL;
      end

      S_UPD_VAL: begin
        address_d = entry_addr(idx_q, 3'd6);
        wr_en_d   = 1'b1;
        wdata_d   = cluster_q;
        state_d   = S_UPD_CLU;
      end

      S_UPD_CLU: begin
        done_d  = 1'b1;
`ifdef LEARN_COSTS_REINIT_EN
        reinit_d = clu_diff_q;
`endif
        state_d = S_FINISH;
      end

      S_APP_ID: begin
        address_d = entry_addr(idx_q, 3'd2);
        wr_en_d   = 1'b1;
        wdata_d   = battery_q;
        state_d   = S_APP_BAT;
      end

      S_APP_BAT: begin
        address_d = entry_addr(idx_q, 3'd4);
        wr_en_d   = 1'b1;
        wdata_d   = value_q;
        state_d   = S_APP_VAL;
      end

      S_APP_VAL: begin
        address_d = entry_addr(idx_q, 3'd6);
        wr_en_d   = 1'b1;
        wdata_d   = cluster_q;
        state_d   = S_APP_CLU;
      end

      S_APP_CLU: begin
        address_d = COUNT_ADDR;
        wr_en_d   = 1'b1;
        wdata_d   = {11'b0, count_q + 5'd1};
        state_d   = S_APP_CNT;
      end

      S_APP_CNT: begin
        done_d  = 1'b1;
`ifdef LEARN_COSTS_REINIT_EN
        reinit_d = 1'b1;
`endif
        state_d = S_FINISH;
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // All state and registered outputs; reset aborts any operation at once.
  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      state_q   <= S_IDLE;
      src_id_q  <= 16'h0000;
      battery_q <= 16'h0000;
      value_q   <= 16'h0000;
      cluster_q <= 16'h0000;
      count_q   <= 5'd0;
      idx_q     <= 5'd0;
      address_q <= 16'h0000;
      wr_en_q   <= 1'b0;
      wdata_q   <= 16'h0000;
      done_q    <= 1'b0;
`ifdef LEARN_COSTS_REINIT_EN
      reinit_q   <= 1'b0;
      clu_diff_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      src_id_q  <= src_id_d;
      battery_q <= battery_d;
      value_q   <= value_d;
      cluster_q <= cluster_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      address_q <= address_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
`ifdef LEARN_COSTS_REINIT_EN
      reinit_q   <= reinit_d;
      clu_diff_q <= clu_diff_d;
`endif
    end
  end

  assign address     = address_q;
  assign wr_en       = wr_en_q;
  assign mem_data_in = wdata_q;
  assign done        = done_q;
`ifdef LEARN_COSTS_REINIT_EN
  assign reinit      = reinit_q;
`else
  assign reinit      = 1'b0;
`endif

endmodule

// File: tb/tb_learn_costs.sv
// tb_learn_costs: self-checking bench for learn_costs with a word-wide
// synchronous memory model, a directed vector table, corner sequences
// (table full, saturated count, busy strobe, reset mid-append) and a
// randomized phase compared against a table-level reference model.
module tb_learn_costs;

`ifdef LEARN_COSTS_REINIT_EN
  localparam int RE = 1;
`else
  localparam int RE = 0;
`endif

  logic        clock = 1'b0;
  logic        nrst;
  logic        en;
  logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID;
  logic [15:0] address, memDataIn, memRdData;
  logic        wrEn, reinit, done;

  logic [15:0] mem    [0:1023];
  logic [15:0] shadow [0:1023];
  logic        bdWe = 1'b0;
  logic [9:0]  bdIdx = 10'd0;
  logic [15:0] bdData = 16'h0000;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] id, bat, val, clu;
    int expLat, expRe, expWr, expCount, expIdx;
  } vec_t;
  vec_t vecs [5];

  always #5 clock = ~clock;

  learn_costs dut (
    .clock(clock), .nrst(nrst), .en(en),
    .fsourceID(fsourceID), .fbatteryStat(fbatteryStat),
    .fValue(fValue), .fclusterID(fclusterID),
    .address(address), .wr_en(wrEn),
    .mem_data_out(memRdData), .mem_data_in(memDataIn),
    .reinit(reinit), .done(done)
  );

  // Synchronous-read memory with a bench-only backdoor write port.
  always @(posedge clock) begin
    if (bdWe) mem[bdIdx] <= bdData;
    else if (wrEn) mem[address[10:1]] <= memDataIn;
    memRdData <= mem[address[10:1]];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic memWrite(input int idx, input logic [15:0] data);
    bdIdx  = idx[9:0];
    bdData = data;
    bdWe   = 1'b1;
    @(posedge clock);
    #1 bdWe = 1'b0;
    shadow[idx] = data;
  endtask

  task automatic writeEntry(input int k, input logic [15:0] id, bat, val, clu);
    memWrite(8 + 4 * k, id);
    memWrite(9 + 4 * k, bat);
    memWrite(10 + 4 * k, val);
    memWrite(11 + 4 * k, clu);
  endtask

  task automatic preloadBase();
    for (int k = 2; k < 16; k++) writeEntry(k, 16'h0, 16'h0, 16'h0, 16'h0);
    writeEntry(0, 16'd30, 16'd1, 16'd1, 16'd1);
    writeEntry(1, 16'd31, 16'd2, 16'd3, 16'd4);
    memWrite(4, 16'd2);
  endtask

  // Table-level reference: find first matching ID among min(count,16)
  // entries, update or append, and derive cost in cycles from the rules.
  task automatic modelOp(input logic [15:0] id, bat, val, clu,
                         output int lat, output int re, output int wr);
    int n, hit, b;
    n   = (int'(shadow[4]) > 16) ? 16 : int'(shadow[4]);
    hit = -1;
    for (int k = 0; k < n; k++)
      if (hit < 0 && shadow[8 + 4 * k] == id) hit = k;
    if (hit >= 0) begin
      b  = 8 + 4 * hit;
      re = (shadow[b + 3] != clu) ? RE : 0;
      lat = 2 + 2 * (hit + 1) + RE + 3 + 1;
      wr = 3;
      shadow[b + 1] = bat;
      shadow[b + 2] = val;
      shadow[b + 3] = clu;
    end else if (n < 16) begin
      b  = 8 + 4 * n;
      shadow[b] = id;
      shadow[b + 1] = bat;
      shadow[b + 2] = val;
      shadow[b + 3] = clu;
      shadow[4] = 16'(n + 1);
      re  = RE;
      lat = 2 + 2 * n + 5 + 1;
      wr  = 5;
    end else begin
      re  = 0;
      lat = 2 + 2 * n + 1;
      wr  = 0;
    end
  endtask

  task automatic checkTable(input string name);
    int bad;
    bad = 0;
    if (mem[4] !== shadow[4]) bad++;
    for (int w = 8; w < 72; w++) if (mem[w] !== shadow[w]) bad++;
    checkOutput({name, "_table"}, bad, 0);
  endtask

  // Pulse en for one accepting edge, then observe the operation at each
  // falling edge; busyAt > 0 injects a second en pulse at that cycle.
  task automatic applyStimulus(input logic [15:0] id, bat, val, clu, input int busyAt,
                               output int lat, output int doneCnt, output int reAtDone,
                               output int writes, output int viol);
    lat = -1; doneCnt = 0; reAtDone = 0; writes = 0; viol = 0;
    @(negedge clock);
    en = 1'b1; fsourceID = id; fbatteryStat = bat; fValue = val; fclusterID = clu;
    @(posedge clock);
    @(negedge clock);
    en = 1'b0;
    fsourceID = 16'($urandom); fbatteryStat = 16'($urandom);
    fValue = 16'($urandom); fclusterID = 16'($urandom);
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (busyAt != 0 && cyc == busyAt) en = 1'b1;
      if (busyAt != 0 && cyc == busyAt + 1) en = 1'b0;
      if (wrEn) begin
        writes++;
        if (address[0]) viol++;
      end else if (memDataIn != 16'h0) viol++;
      if (done) begin
        doneCnt++;
        if (lat < 0) begin
          lat = cyc;
          reAtDone = int'(reinit);
        end
      end else if (reinit) viol++;
      if (lat >= 0 && cyc >= lat + 3) break;
      @(negedge clock);
    end
    en = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [15:0] id, bat, val, clu, input int busyAt,
                       output int aLat, output int aRe, output int aWr);
    int mLat, mRe, mWr, dCnt, viol;
    modelOp(id, bat, val, clu, mLat, mRe, mWr);
    applyStimulus(id, bat, val, clu, busyAt, aLat, dCnt, aRe, aWr, viol);
    checkOutput({name, "_latency"}, aLat, mLat);
    checkOutput({name, "_reinit"}, aRe, mRe);
    checkOutput({name, "_writes"}, aWr, mWr);
    checkOutput({name, "_done_pulses"}, dCnt, 1);
    checkOutput({name, "_idle_outputs"}, viol, 0);
    checkTable(name);
  endtask

  initial begin
    int aLat, aRe, aWr, bad, seen, cnt;
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int aLat, aRe, aWr, bad, seen, cnt;
    vecs[0] = '{16'd31, 16'd5, 16'd10, 16'd11, 10 + RE, RE, 3, 2, 1};
    vecs[1] = '{16'd31, 16'd5, 16'd10, 16'd11, 10 + RE, 0,  3, 2, 1};
    vecs[2] = '{16'd1,  16'd5, 16'd10, 16'd11, 12,      RE, 5, 3, 2};
    vecs[3] = '{16'd30, 16'd7, 16'd8,  16'd1,  8 + RE,  0,  3, 3, 0};
    vecs[4] = '{16'd1,  16'd9, 16'd9,  16'd9,  12 + RE, RE, 3, 3, 2};

    nrst = 1'b1; en = 1'b0;
    fsourceID = 16'h0; fbatteryStat = 16'h0; fValue = 16'h0; fclusterID = 16'h0;
    repeat (2) @(negedge clock);
    checkOutput("reset_address", int'(address), 0);
    checkOutput("reset_wr_en", int'(wrEn), 0);
    checkOutput("reset_data", int'(memDataIn), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_reinit", int'(reinit), 0);
    nrst = 1'b0;

    // Directed vector table on the shared two-entry preload.
    preloadBase();
    for (int r = 0; r < 5; r++) begin
      runOp($sformatf("vec%0d", r), vecs[r].id, vecs[r].bat, vecs[r].val, vecs[r].clu, 0,
            aLat, aRe, aWr);
      checkOutput($sformatf("vec%0d_lat_const", r), aLat, vecs[r].expLat);
      checkOutput($sformatf("vec%0d_reinit_const", r), aRe, vecs[r].expRe);
      checkOutput($sformatf("vec%0d_writes_const", r), aWr, vecs[r].expWr);
      checkOutput($sformatf("vec%0d_count_const", r), int'(mem[4]), vecs[r].expCount);
      bad = 0;
      if (mem[8 + 4 * vecs[r].expIdx] !== vecs[r].id)  bad++;
      if (mem[9 + 4 * vecs[r].expIdx] !== vecs[r].bat) bad++;
      if (mem[10 + 4 * vecs[r].expIdx] !== vecs[r].val) bad++;
      if (mem[11 + 4 * vecs[r].expIdx] !== vecs[r].clu) bad++;
      checkOutput($sformatf("vec%0d_entry_const", r), bad, 0);
    end
    checkOutput("append_at_0x20", int'(mem[16]), 1);

    // Full table: 16 entries, unknown ID, nothing written.
    for (int k = 0; k < 16; k++) writeEntry(k, 16'(100 + k), 16'd1, 16'd2, 16'd3);
    memWrite(4, 16'd16);
    runOp("full", 16'd99, 16'd5, 16'd6, 16'd7, 0, aLat, aRe, aWr);
    checkOutput("full_writes_const", aWr, 0);
    checkOutput("full_lat_const", aLat, 35);
    checkOutput("full_reinit_const", aRe, 0);

    // Count word beyond capacity saturates: miss is full, last entry still matches.
    memWrite(4, 16'd20);
    runOp("sat_miss", 16'd99, 16'd5, 16'd6, 16'd7, 0, aLat, aRe, aWr);
    runOp("sat_hit15", 16'd115, 16'd5, 16'd6, 16'd7, 0, aLat, aRe, aWr);
    checkOutput("sat_hit15_lat_const", aLat, 38 + RE);

    // Second strobe mid-search is ignored.
    preloadBase();
    runOp("busy", 16'd31, 16'd8, 16'd9, 16'd4, 4, aLat, aRe, aWr);

    // Empty table appends at entry 0.
    memWrite(4, 16'd0);
    runOp("empty", 16'd77, 16'd1, 16'd2, 16'd3, 0, aLat, aRe, aWr);
    checkOutput("empty_lat_const", aLat, 8);

    // Reset in the middle of an append.
    preloadBase();
    @(negedge clock);
    en = 1'b1; fsourceID = 16'd50; fbatteryStat = 16'd6; fValue = 16'd7; fclusterID = 16'd8;
    @(posedge clock);
    @(negedge clock);
    en = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      if (wrEn) seen = 1;
      else @(negedge clock);
    end
    checkOutput("rst_append_started", seen, 1);
    @(negedge clock);
    #2 nrst = 1'b1;
    #1;
    checkOutput("rst_mid_address", int'(address), 0);
    checkOutput("rst_mid_wr_en", int'(wrEn), 0);
    checkOutput("rst_mid_data", int'(memDataIn), 0);
    checkOutput("rst_mid_done", int'(done), 0);
    checkOutput("rst_mid_reinit", int'(reinit), 0);
    @(negedge clock);
    nrst = 1'b0;
    checkOutput("rst_count_kept", int'(mem[4]), 2);
    preloadBase();
    runOp("after_rst", 16'd50, 16'd6, 16'd7, 16'd8, 0, aLat, aRe, aWr);

    // Randomized tables and packets against the reference model.
    for (int it = 0; it < 30; it++) begin
      cnt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 20)) : int'($urandom_range(0, 16));
      for (int k = 0; k < 16; k++)
        writeEntry(k, 16'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                   16'($urandom_range(0, 3)));
      memWrite(4, 16'(cnt));
      runOp($sformatf("rand%0d", it), 16'($urandom_range(0, 8)), 16'($urandom),
            16'($urandom), 16'($urandom_range(0, 3)), 0, aLat, aRe, aWr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
